// File: rtl/fifo_axis_reader.sv
// Drains a first-word-fall-through FIFO read port into an AXI-Stream master
// through a 2-entry head/skid buffer, with tlast generation and status counters.
//
// state  | meaning
// OCC_0  | buffer empty, tvalid low
// OCC_1  | head holds a word
// OCC_2  | head and skid both hold words, popping stalls
module fifo_axis_reader #(
   parameter int DWIDTH = 32,
   parameter int LEN_W  = 16,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DWIDTH-1:0] fifo_rd_data,
   input  logic              fifo_rd_empty,
   output logic              fifo_rd_en,
   input  logic [LEN_W-1:0]  pkt_len,
   output logic [DWIDTH-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              m_axis_tlast,
   output logic              busy,
   output logic [CNT_W-1:0]  pkt_cnt,
   output logic [CNT_W-1:0]  word_cnt
);

   typedef enum logic [1:0] {OCC_0, OCC_1, OCC_2} occ_t;

   occ_t              state_q, state_d;
   logic [DWIDTH-1:0] head_data_q, skid_data_q;
   logic              head_last_q, skid_last_q;
   logic [LEN_W-1:0]  beat_q, len_q, len_eff;
   logic              busy_q;
   logic [CNT_W-1:0]  pkt_cnt_q, word_cnt_q;

   logic pop, xfer, new_last, first_pop;
   logic load_head_new, load_head_skid, load_skid_new;

   // Pop is independent of tready: only registered occupancy gates it.
   assign pop  = rst_n & ~fifo_rd_empty & (state_q != OCC_2);
   assign xfer = m_axis_tvalid & m_axis_tready;

   assign len_eff   = (beat_q != '0) ? len_q : ((pkt_len == '0) ? LEN_W'(1) : pkt_len);
   assign new_last  = (beat_q == (len_eff - LEN_W'(1)));
   assign first_pop = pop & (beat_q == '0);

   always_comb begin
      state_d        = state_q;
      load_head_new  = 1'b0;
      load_head_skid = 1'b0;
      load_skid_new  = 1'b0;
      case (state_q)
         OCC_0: begin
            if (pop) begin
               load_head_new = 1'b1;
               state_d       = OCC_1;
            end
         end
         OCC_1: begin
            if (pop && xfer) begin
               load_head_new = 1'b1;
            end else if (pop) begin
               load_skid_new = 1'b1;
               state_d       = OCC_2;
            end else if (xfer) begin
               state_d = OCC_0;
            end
         end
         OCC_2: begin
            if (xfer) begin
               load_head_skid = 1'b1;
               if (pop) begin
                  load_skid_new = 1'b1;
               end else begin
                  state_d = OCC_1;
               end
            end
         end
         default: state_d = OCC_0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= OCC_0;
         head_data_q <= '0;
         head_last_q <= 1'b0;
         skid_data_q <= '0;
         skid_last_q <= 1'b0;
         beat_q      <= '0;
         len_q       <= '0;
         busy_q      <= 1'b0;
         pkt_cnt_q   <= '0;
         word_cnt_q  <= '0;
      end else begin
         state_q <= state_d;
         if (load_head_new) begin
            head_data_q <= fifo_rd_data;
            head_last_q <= new_last;
         end else if (load_head_skid) begin
            head_data_q <= skid_data_q;
            head_last_q <= skid_last_q;
         end
         if (load_skid_new) begin
            skid_data_q <= fifo_rd_data;
            skid_last_q <= new_last;
         end
         if (pop) begin
            len_q  <= len_eff;
            beat_q <= new_last ? '0 : beat_q + LEN_W'(1);
         end
         // A new packet opening wins over the previous packet's tlast leaving.
         if (first_pop) begin
            busy_q <= 1'b1;
         end else if (xfer && head_last_q) begin
            busy_q <= 1'b0;
         end
         if (xfer) begin
            word_cnt_q <= word_cnt_q + CNT_W'(1);
            if (head_last_q) begin
               pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
            end
         end
      end
   end

   assign fifo_rd_en    = pop;
   assign m_axis_tvalid = (state_q != OCC_0);
   assign m_axis_tdata  = head_data_q;
   assign m_axis_tlast  = head_last_q;
   assign busy          = busy_q;
   assign pkt_cnt       = pkt_cnt_q;
   assign word_cnt      = word_cnt_q;

endmodule
